// File: rtl/alu_sequencer_if.sv
// Command/result handshake bundle for alu_sequencer.
// The slave modport is the sequencer side and the master modport is the requester side.
interface alu_sequencer_if #(
    parameter int m = 4,
    parameter int n = 2
);
    logic         i_valid;
    logic         o_ready;
    logic [1:0]   i_op;
    logic [m-1:0] i_argA;
    logic [m-1:0] i_argB;
    logic         o_valid;
    logic         i_ack;
    logic [m-1:0] o_result;
    logic [n-1:0] o_status;
    logic         o_busy;
    logic [7:0]   o_count;

    modport slave (
        input  i_valid, i_op, i_argA, i_argB, i_ack,
        output o_ready, o_valid, o_result, o_status, o_busy, o_count
    );

    modport master (
        output i_valid, i_op, i_argA, i_argB, i_ack,
        input  o_ready, o_valid, o_result, o_status, o_busy, o_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// Three-state command sequencer around a small ALU (SUB, LT, SETBIT, SM2U2).
// Every output is a register; the result is held until the requester acknowledges it.
module alu_sequencer #(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    alu_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [1:0] OP_SUB    = 2'b00;
    localparam logic [1:0] OP_LT     = 2'b01;
    localparam logic [1:0] OP_SETBIT = 2'b10;
    localparam logic [1:0] OP_SM2U2  = 2'b11;

    logic [1:0]   state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [m-1:0] a_q, a_d;
    logic [m-1:0] b_q, b_d;
    logic [m-1:0] result_q, result_d;
    logic [n-1:0] status_q, status_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic [7:0]   count_q, count_d;

    // Returns {result, status}; status 2'b11 is never produced.
    function automatic logic [m+1:0] alu_eval(
        input logic [1:0]   op,
        input logic [m-1:0] a,
        input logic [m-1:0] b
    );
        logic [m-1:0] r;
        logic [1:0]   s;
        logic [m-1:0] one;
        one = {{(m-1){1'b0}}, 1'b1};
        r   = {m{1'b0}};
        s   = 2'b00;
        case (op)
            OP_SUB: begin
                r = a - b;
                s = (a < b) ? 2'b01 : 2'b00;
            end
            OP_LT: begin
                r = (a < b) ? one : {m{1'b0}};
                s = 2'b00;
            end
            OP_SETBIT: begin
                if (32'(b) < 32'(m)) begin
                    r = a | (one << b);
                    s = 2'b00;
                end else begin
                    r = {m{1'b0}};
                    s = 2'b10;
                end
            end
            OP_SM2U2: begin
                if (a[m-1] == 1'b0) begin
                    r = a;
                    s = 2'b00;
                end else if (a[m-2:0] != {(m-1){1'b0}}) begin
                    r = {m{1'b0}} - {1'b0, a[m-2:0]};
                    s = r[m-1] ? 2'b01 : 2'b00;
                end else begin
                    // negative zero has no unsigned image
                    r = {m{1'b0}};
                    s = 2'b10;
                end
            end
            default: begin
                r = {m{1'b0}};
                s = 2'b00;
            end
        endcase
        return {r, s};
    endfunction

    // Next-state and datapath decode for the IDLE/EXEC/HOLD sequence.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        status_d = status_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (ready_q && bus.i_valid) begin
                    op_d    = bus.i_op;
                    a_d     = bus.i_argA;
                    b_d     = bus.i_argB;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                {result_d, status_d} = alu_eval(op_q, a_q, b_q);
                state_d              = S_HOLD;
            end
            S_HOLD: begin
                if (valid_q && bus.i_ack) begin
                    count_d = count_q + 8'd1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // o_valid rises one edge into HOLD, so a result is valid two edges after acceptance
        ready_d = (state_d == S_IDLE);
        valid_d = (state_q == S_HOLD) && (state_d == S_HOLD);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            a_q      <= {m{1'b0}};
            b_q      <= {m{1'b0}};
            result_q <= {m{1'b0}};
            status_q <= {n{1'b0}};
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            status_q <= status_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_status = status_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_count  = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a driver queues model results at acceptance,
// a forked monitor pops and compares whenever a new result becomes valid.
module tb_alu_sequencer;

    localparam int M = 4;

    typedef struct {
        int r;
        int s;
        int t;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   fails;
    int   exp_cnt;
    int   ack_mode;
    exp_t exp_q[$];

    alu_sequencer_if #(.m(M), .n(2)) bus ();

    alu_sequencer #(.m(M), .n(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural reference written from the operation definitions with integer arithmetic.
    function automatic void model(input int op, input int a, input int b, output int r, output int s);
        int half;
        int full;
        half = 1 << (M - 1);
        full = 1 << M;
        case (op)
            0: begin r = (a - b + full) % full; s = (a < b) ? 1 : 0; end
            1: begin r = (a < b) ? 1 : 0; s = 0; end
            2: begin
                if (b < M) begin r = a | (1 << b); s = 0; end
                else begin r = 0; s = 2; end
            end
            default: begin
                if (a < half) begin r = a; s = 0; end
                else if (a == half) begin r = 0; s = 2; end
                else begin r = full - (a - half); s = (r >= half) ? 1 : 0; end
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor_loop();
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_valid === 1'b1 && prev_v == 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_result actual=%0d required=none (cycle %0d)", bus.o_result, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'(bus.o_result), e.r);
                    chk("status", 32'(bus.o_status), e.s);
                    chk("accept_to_valid", cyc - e.t, 2);
                end
            end
            prev_v = bus.o_valid;
        end
    endtask

    task automatic ack_loop();
        forever begin
            @(negedge clk);
            case (ack_mode)
                0:       bus.i_ack = 1'($urandom_range(0, 1));
                1:       bus.i_ack = 1'b1;
                default: bus.i_ack = 1'b0;
            endcase
        end
    endtask

    // Presents one command and returns the edge number at which it was accepted.
    task automatic send(input int op, input int a, input int b, output int t);
        int   w;
        int   r;
        int   s;
        exp_t e;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op    = 2'(op);
        bus.i_argA  = M'(a);
        bus.i_argB  = M'(b);
        w = 0;
        while (bus.o_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            checks++;
            fails++;
            $display("FAIL send_timeout actual=not_ready required=ready (cycle %0d)", cyc);
            bus.i_valid = 1'b0;
            t = -1;
        end else begin
            t = cyc + 1;
            model(op, a, b, r, s);
            e.r = r;
            e.s = s;
            e.t = t;
            exp_q.push_back(e);
            exp_cnt++;
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.i_op    = 2'($urandom_range(0, 3));
            bus.i_argA  = M'($urandom_range(0, 15));
            bus.i_argB  = M'($urandom_range(0, 15));
            chk("ready_low_after_accept", 32'(bus.o_ready), 0);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || bus.o_ready !== 1'b1) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout actual=pending%0d required=pending0 (cycle %0d)", exp_q.size(), cyc);
        end
    endtask

    task automatic wait_valid();
        int w;
        w = 0;
        while (bus.o_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            checks++;
            fails++;
            $display("FAIL valid_timeout actual=0 required=1 (cycle %0d)", cyc);
        end
    endtask

    task automatic reset_and_check();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_cnt = 0;
        chk("rst_ready", 32'(bus.o_ready), 0);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_result", 32'(bus.o_result), 0);
        chk("rst_status", 32'(bus.o_status), 0);
        chk("rst_count", 32'(bus.o_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(bus.o_ready), 1);
    endtask

    initial begin
        int t;
        int w;
        int dir_op[10];
        int dir_a[10];
        int dir_b[10];
        rst_n       = 1'b0;
        cyc         = 0;
        checks      = 0;
        fails       = 0;
        exp_cnt     = 0;
        ack_mode    = 1;
        bus.i_valid = 1'b0;
        bus.i_op    = 2'b00;
        bus.i_argA  = '0;
        bus.i_argB  = '0;
        bus.i_ack   = 1'b0;
        fork
            monitor_loop();
            ack_loop();
        join_none

        reset_and_check();

        // SUB 3-5 with immediate acknowledge
        send(0, 3, 5, t);
        wait_idle();
        chk("count_after_first", 32'(bus.o_count), 1);

        dir_op = '{2, 2, 3, 3, 3, 0, 3, 1, 0, 2};
        dir_a  = '{1, 1, 11, 8, 6, 9, 15, 7, 0, 15};
        dir_b  = '{2, 4, 0, 0, 0, 9, 0, 7, 1, 3};
        for (int i = 0; i < 10; i++) send(dir_op[i], dir_a[i], dir_b[i], t);
        wait_idle();
        chk("count_directed", 32'(bus.o_count), exp_cnt % 256);

        // LT held unacknowledged while a new command is offered
        ack_mode = 2;
        send(1, 2, 7, t);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            bus.i_valid = 1'b1;
            bus.i_op    = 2'($urandom_range(0, 3));
            bus.i_argA  = M'($urandom_range(0, 15));
            bus.i_argB  = M'($urandom_range(0, 15));
            @(negedge clk);
            chk("hold_valid", 32'(bus.o_valid), 1);
            chk("hold_result", 32'(bus.o_result), 1);
            chk("hold_status", 32'(bus.o_status), 0);
            chk("hold_ready", 32'(bus.o_ready), 0);
        end
        bus.i_valid = 1'b0;
        ack_mode = 1;
        wait_idle();
        chk("count_after_hold", 32'(bus.o_count), exp_cnt % 256);

        // reset while holding a result
        ack_mode = 2;
        send(2, 1, 2, t);
        wait_valid();
        rst_n = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        chk("abort_hold_valid", 32'(bus.o_valid), 0);
        chk("abort_hold_result", 32'(bus.o_result), 0);
        chk("abort_hold_count", 32'(bus.o_count), 0);
        chk("abort_hold_busy", 32'(bus.o_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_hold_ready", 32'(bus.o_ready), 1);

        // reset while executing: the result must never appear
        ack_mode = 1;
        send(0, 5, 3, t);
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_exec_valid", 32'(bus.o_valid), 0);
        end
        chk("abort_exec_count", 32'(bus.o_count), 0);

        // randomized commands with random acknowledge timing
        ack_mode = 0;
        for (int i = 0; i < 200; i++)
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), t);
        ack_mode = 1;
        wait_idle();
        chk("count_random", 32'(bus.o_count), exp_cnt % 256);

        // 256 acknowledged commands: count wraps and re-ready takes 3 edges
        reset_and_check();
        ack_mode = 1;
        for (int i = 0; i < 256; i++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), t);
            w = 0;
            while (bus.o_ready !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("accept_to_ready", cyc - t, 3);
        end
        wait_idle();
        chk("count_wrap", 32'(bus.o_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter m, default 4, operand and result width in bits; the block SHALL support any m from 3 to 16.
REQ-002 Parameter n, default 2, status width in bits; the block SHALL be used only with n = 2.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous and active-low.
REQ-005 i_valid  input  1  command valid.
REQ-006 o_ready  output  1  command accepted when i_valid && o_ready at a rising edge.
REQ-007 i_op  input  2  opcode: 00 SUB, 01 LT, 10 SETBIT, 11 SM2U2.
REQ-008 i_argA  input  m  operand A.
REQ-009 i_argB  input  m  operand B.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ack  input  1  result consumed when o_valid && i_ack at a rising edge.
REQ-012 o_result  output  m  registered result.
REQ-013 o_status  output  n  registered status.
REQ-014 o_busy  output  1  high in any state other than IDLE.
REQ-015 o_count  output  8  count of completed (acknowledged) operations, wrapping 255 -> 0.

Function
REQ-016 FSM states SHALL be IDLE, EXEC and HOLD, encoded in registers.
REQ-017 IDLE: o_ready = 1; on i_valid, latch i_op, i_argA and i_argB into internal registers, then go to EXEC.
REQ-018 EXEC: o_ready = 0; compute from the latched operands only, register o_result and o_status, then go to HOLD.
REQ-019 HOLD: o_ready = 0 and o_valid = 1; o_result and o_status stay stable; on i_ack, increment o_count and go to IDLE.
REQ-020 Latency: command accepted at edge t -> o_valid high after edge t+2; the next command SHALL NOT be accepted before the edge following the acknowledge.
REQ-021 Changes on i_valid, i_op, i_argA and i_argB outside IDLE SHALL have no effect.
REQ-022 i_ack outside HOLD SHALL be ignored.
REQ-023 SUB: result = (A - B) mod 2^m; status = 01 if A < B unsigned (borrow), else 00.
REQ-024 LT: result = 1 (zero-extended to m bits) if A < B unsigned, else 0; status = 00.
REQ-025 SETBIT: if B < m unsigned, result = A with bit B set and status = 00.
REQ-026 SETBIT: if B >= m, result = 0 and status = 10 (index error).
REQ-027 SM2U2, A[m-1] = 0: result = A.
REQ-028 SM2U2, A[m-1] = 1 and magnitude A[m-2:0] != 0: result = two's complement negation of {0, A[m-2:0]}.
REQ-029 SM2U2, A = {1, 0...0} (negative zero): result = 0 and status = 10.
REQ-030 SM2U2 status for all other cases: 01 if result[m-1] = 1, else 00.
REQ-031 Status code 11 is reserved and SHALL never be produced.
REQ-032 All outputs SHALL be driven from registers or decoded from the FSM state only; no combinational path from any input to any output.

Reset
REQ-033 While i_rst_n = 0 at a rising edge, next state SHALL be IDLE.
REQ-034 Reset values: o_result = 0, o_status = 00, o_valid = 0, o_busy = 0, o_count = 0, internal operand and op registers = 0.
REQ-035 o_ready SHALL be 0 during the cycles reset is asserted and 1 from the first edge after reset release.
REQ-036 Reset asserted in EXEC or HOLD SHALL abort the operation: no result is delivered and o_count does not increment.

Verification
REQ-037 m=4: SUB with A=3, B=5, ack after 1 cycle in HOLD -> o_result=1110, o_status=01, o_valid at t+2, o_count=1.
REQ-038 m=4: SETBIT with A=0001, B=2 -> o_result=0101, o_status=00; then SETBIT with B=4 -> o_result=0000, o_status=10.
REQ-039 m=4: SM2U2 with A=1011 -> 1101/01; with A=1000 -> 0000/10; with A=0110 -> 0110/00.
REQ-040 LT with A=2, B=7 -> 0001; hold i_ack=0 for 5 cycles -> o_valid, o_result and o_status stable, o_ready=0, and a new i_valid is ignored.
REQ-041 Pulse i_rst_n=0 while in HOLD -> next edge: o_valid=0, o_result=0, o_count unchanged-from-reset = 0, state IDLE.
REQ-042 Run 256 back-to-back acknowledged commands -> o_count wraps to 0, and each command takes exactly 3 cycles from accept to re-ready when i_ack=1 constantly.
